// File: rtl/gcd_result_display.sv
// gcd_result_display: latches the processor result on Halt rise, converts it to BCD, scans it onto a 3-digit display
module gcd_result_display #(
   parameter int REFRESH_CYCLES = 4
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Halt,
   input  logic [7:0]  Value,
   output logic [11:0] Bcd,
   output logic        Valid,
   output logic        Busy,
   output logic [6:0]  Seg,
   output logic [2:0]  An
);
   typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
   localparam int RW = REFRESH_CYCLES > 1 ? $clog2(REFRESH_CYCLES) : 1;
   localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);
   localparam logic [6:0] DASH = 7'b0111111;
   localparam logic [6:0] BLANK = 7'b1111111;
   state_t state_q, state_d;
   logic halt_dly_q, halt_dly_d;
   logic [19:0] sh_q, sh_d, adj;
   logic [2:0] cnt_q, cnt_d;
   logic [11:0] bcd_q, bcd_d;
   logic valid_q, valid_d, busy_q, busy_d;
   logic [RW-1:0] ref_q, ref_d;
   logic [1:0] idx_q, idx_d;
   logic [6:0] seg_q, seg_d;
   logic [2:0] an_q, an_d;
   logic [3:0] dig;
   logic blank;
   function automatic logic [3:0] add3(input logic [3:0] n);
      return n >= 4'd5 ? n + 4'd3 : n;
   endfunction
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0: return 7'b1000000;
         4'd1: return 7'b1111001;
         4'd2: return 7'b0100100;
         4'd3: return 7'b0110000;
         4'd4: return 7'b0011001;
         4'd5: return 7'b0010010;
         4'd6: return 7'b0000010;
         4'd7: return 7'b1111000;
         4'd8: return 7'b0000000;
         4'd9: return 7'b0010000;
         default: return BLANK;
      endcase
   endfunction
   assign adj = {add3(sh_q[19:16]), add3(sh_q[15:12]), add3(sh_q[11:8]), sh_q[7:0]};
   always_comb begin
      state_d = state_q;
      halt_dly_d = Halt;
      sh_d = sh_q;
      cnt_d = cnt_q;
      bcd_d = bcd_q;
      valid_d = valid_q;
      busy_d = busy_q;
      case (state_q)
         IDLE: if (Halt && !halt_dly_q) begin
            sh_d = {12'b0, Value};
            cnt_d = 3'd0;
            busy_d = 1'b1;
            state_d = CONVERT;
         end
         CONVERT: begin
            sh_d = 20'({adj, 1'b0});
            cnt_d = cnt_q + 3'd1;
            state_d = cnt_q == 3'd7 ? DONE : CONVERT;
         end
         DONE: begin
            bcd_d = sh_q[19:8];
            valid_d = 1'b1;
            busy_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   // Seg/An are computed from the next scan index so both registers move together
   always_comb begin
      ref_d = ref_q == REF_LAST ? '0 : ref_q + 1'b1;
      idx_d = ref_q != REF_LAST ? idx_q : idx_q == 2'd2 ? 2'd0 : idx_q + 2'd1;
      an_d = idx_d == 2'd0 ? 3'b110 : idx_d == 2'd1 ? 3'b101 : 3'b011;
      dig = idx_d == 2'd0 ? bcd_q[3:0] : idx_d == 2'd1 ? bcd_q[7:4] : bcd_q[11:8];
      blank = (idx_d == 2'd2 && bcd_q[11:8] == 4'd0) || (idx_d == 2'd1 && bcd_q[11:4] == 8'd0);
      seg_d = !valid_q ? DASH : blank ? BLANK : seg7(dig);
   end
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= IDLE;
         halt_dly_q <= 1'b0;
         sh_q <= '0;
         cnt_q <= '0;
         bcd_q <= '0;
         valid_q <= 1'b0;
         busy_q <= 1'b0;
         ref_q <= '0;
         idx_q <= '0;
         seg_q <= DASH;
         an_q <= 3'b110;
      end else begin
         state_q <= state_d;
         halt_dly_q <= halt_dly_d;
         sh_q <= sh_d;
         cnt_q <= cnt_d;
         bcd_q <= bcd_d;
         valid_q <= valid_d;
         busy_q <= busy_d;
         ref_q <= ref_d;
         idx_q <= idx_d;
         seg_q <= seg_d;
         an_q <= an_d;
      end
   end
   assign Bcd = bcd_q;
   assign Valid = valid_q;
   assign Busy = busy_q;
   assign Seg = seg_q;
   assign An = an_q;
endmodule

// File: tb/tb_gcd_result_display.sv
// tb_gcd_result_display: scoreboard bench for result capture, BCD conversion and display scan
module tb_gcd_result_display;
   localparam int R = 4;
   localparam logic [6:0] DASH = 7'b0111111;
   localparam logic [6:0] BLANK = 7'b1111111;
   logic Clock = 1'b0, Reset, Halt;
   logic [7:0] Value;
   logic [11:0] Bcd;
   logic Valid, Busy;
   logic [6:0] Seg;
   logic [2:0] An;
   int checks = 0, errors = 0;
   logic [11:0] exp_q[$];
   gcd_result_display #(.REFRESH_CYCLES(R)) dut (
      .Clock(Clock), .Reset(Reset), .Halt(Halt), .Value(Value),
      .Bcd(Bcd), .Valid(Valid), .Busy(Busy), .Seg(Seg), .An(An)
   );
   always #5 Clock = ~Clock;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic logic [11:0] bcd_of(input logic [7:0] v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction
   logic busy_prev = 1'b0;
   int blen = 0;
   always @(negedge Clock) begin
      if (Reset) begin
         busy_prev = 1'b0;
         blen = 0;
      end else begin
         if (Busy) blen++;
         if (busy_prev && !Busy) begin
            chk("done_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               chk("bcd", Bcd, exp_q.pop_front());
               chk("valid", Valid, 1);
               chk("busy_len", blen, 9);
            end
            blen = 0;
         end
         busy_prev = Busy;
      end
   end
   task automatic drain();
      for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge Clock);
      chk("drain", exp_q.size(), 0);
   endtask
   task automatic present(input logic [7:0] v);
      @(posedge Clock); #1 Value = v; Halt = 1'b1; exp_q.push_back(bcd_of(v));
      @(posedge Clock); #1 Halt = 1'b0;
      drain();
   endtask
   task automatic scan(input logic [6:0] u, input logic [6:0] t, input logic [6:0] h);
      logic [2:0] seen = 3'b000;
      for (int i = 0; i < 3 * R; i++) begin
         @(negedge Clock);
         case (An)
            3'b110: begin chk("seg_units", Seg, u); seen[0] = 1'b1; end
            3'b101: begin chk("seg_tens", Seg, t); seen[1] = 1'b1; end
            3'b011: begin chk("seg_hundreds", Seg, h); seen[2] = 1'b1; end
            default: chk("an_onehot", An, 3'b110);
         endcase
      end
      chk("scan_cover", seen, 3'b111);
   endtask
   initial begin
      Reset = 1'b1; Halt = 1'b0; Value = 8'd0;
      @(negedge Clock);
      chk("rst_an", An, 3'b110);
      chk("rst_seg", Seg, DASH);
      @(posedge Clock); #1 Reset = 1'b0;
      @(negedge Clock);
      chk("rst_valid", Valid, 0);
      chk("rst_busy", Busy, 0);
      chk("rst_bcd", Bcd, 0);
      scan(DASH, DASH, DASH);
      present(8'd6);
      repeat (2) @(posedge Clock);
      scan(7'b0000010, BLANK, BLANK);
      present(8'd255);
      repeat (2) @(posedge Clock);
      scan(7'b0010010, 7'b0010010, 7'b0100100);
      @(posedge Clock); #1 Value = 8'd105; Halt = 1'b1; exp_q.push_back(bcd_of(8'd105));
      @(posedge Clock); #1 Halt = 1'b0;
      repeat (2) @(posedge Clock);
      #1 Value = 8'd7; Halt = 1'b1;
      @(posedge Clock); #1 Halt = 1'b0;
      @(posedge Clock); #1 Halt = 1'b1;
      drain();
      repeat (20) @(posedge Clock);
      #1 Halt = 1'b0;
      @(negedge Clock);
      chk("no_second_busy", Busy, 0);
      chk("held_bcd", Bcd, 12'h105);
      scan(7'b0010010, 7'b1000000, 7'b1111001);
      @(posedge Clock); #1 Value = 8'd99; Halt = 1'b1;
      @(posedge Clock); #1 Halt = 1'b0;
      repeat (3) @(posedge Clock);
      #1 Reset = 1'b1;
      repeat (2) @(posedge Clock);
      #1 Reset = 1'b0;
      @(negedge Clock);
      chk("abort_bcd", Bcd, 0);
      chk("abort_valid", Valid, 0);
      chk("abort_busy", Busy, 0);
      present(8'd40);
      repeat (2) @(posedge Clock);
      scan(7'b1000000, 7'b0011001, BLANK);
      repeat (100) present(8'($urandom_range(1, 127)));
      repeat (5) @(posedge Clock);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
